sram_loader: RTL and testbench

Write-side SRAM master: the producer end of the SRAM bus that the display path only ever reads. It accepts a stream of 16-bit sprite/background words through a valid/ready handshake and writes them to consecutive SRAM addresses, starting at a programmed base. Each write is a timed setup/WE-pulse/hold cycle. It sits beside the display read path and owns the SRAM bus only while busy; the top level muxes CE/WE/OE/ADDR and the tristate drive enable on busy.

---
 rtl/sram_loader.sv | 136 +++++++++++++
 tb/tb_sram_loader.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sram_loader.sv
// rtl/sram_loader.sv - write-side SRAM master: streams words into consecutive SRAM addresses
// Each word is written with a setup / WE-pulse / hold sequence.
module sram_loader #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 16,
  parameter int WE_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] words_written,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] data_to_tristate,
  output logic              drive_en
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_DATA, S_SETUP, S_PULSE, S_HOLD, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W-1:0] written;
  logic [DATA_W-1:0] data_q;
  logic [3:0]        pulse_cnt;
  logic              abort_q;
  logic              zero_done;
  logic              abort_any;
  logic              start_ok;

  // An abort seen mid-write is remembered so it still ends the burst at the next word boundary.
  assign abort_any = abort | abort_q;
  assign start_ok  = start && (word_count != '0);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Controls decode straight from the state so reset releases WE/drive_en without a clock.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    CE        = 1'b1;
    UB        = 1'b1;
    LB        = 1'b1;
    WE        = 1'b1;
    drive_en  = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start_ok) state_nxt = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        in_ready = 1'b1;
        if (abort_any)     state_nxt = S_DONE;
        else if (in_valid) state_nxt = S_SETUP;
      end
      S_SETUP: begin
        CE = 1'b0; UB = 1'b0; LB = 1'b0; drive_en = 1'b1;
        state_nxt = S_PULSE;
      end
      S_PULSE: begin
        CE = 1'b0; UB = 1'b0; LB = 1'b0; drive_en = 1'b1; WE = 1'b0;
        if (pulse_cnt == 4'd0) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        CE = 1'b0; UB = 1'b0; LB = 1'b0; drive_en = 1'b1;
        if (remaining == ADDR_W'(1) || abort_any) state_nxt = S_DONE;
        else                                      state_nxt = S_WAIT_DATA;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cur_addr  <= '0;
      remaining <= '0;
      written   <= '0;
      data_q    <= '0;
      pulse_cnt <= '0;
      abort_q   <= 1'b0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= (state == S_IDLE) && start && (word_count == '0);
      if (state == S_IDLE) abort_q <= 1'b0;
      else if (abort)      abort_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            cur_addr  <= base_addr;
            remaining <= word_count;
            written   <= '0;
          end
        end
        S_WAIT_DATA: begin
          if (!abort_any && in_valid) data_q <= in_data;
        end
        S_SETUP: pulse_cnt <= 4'(WE_CYCLES - 1);
        S_PULSE: begin
          if (pulse_cnt != 4'd0) pulse_cnt <= pulse_cnt - 4'd1;
        end
        S_HOLD: begin
          written   <= written + ADDR_W'(1);
          remaining <= remaining - ADDR_W'(1);
          cur_addr  <= cur_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign OE               = 1'b1;
  assign ADDR             = cur_addr;
  assign data_to_tristate = data_q;
  assign words_written    = written;
  assign done             = (state == S_DONE) || zero_done;

endmodule

// File: tb/tb_sram_loader.sv
// tb/tb_sram_loader.sv - self-checking bench for sram_loader
// Random data words, a write-capture monitor and a per-burst expected write list.
module tb_sram_loader;
  localparam int AW  = 20;
  localparam int DW  = 16;
  localparam int WEC = 2;
  localparam int GAP = 4;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] word_count = '0;
  logic          abort = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, busy, done, CE, UB, LB, OE, WE, drive_en;
  logic [AW-1:0] words_written, ADDR;
  logic [DW-1:0] data_to_tristate;

  sram_loader #(.ADDR_W(AW), .DATA_W(DW), .WE_CYCLES(WEC)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .abort(abort), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .busy(busy), .done(done),
    .words_written(words_written), .CE(CE), .UB(UB), .LB(LB), .OE(OE),
    .WE(WE), .ADDR(ADDR), .data_to_tristate(data_to_tristate),
    .drive_en(drive_en)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] src[$];
  logic [DW-1:0] fixed_q[$];
  logic [AW-1:0] got_addr[$];
  logic [DW-1:0] got_data[$];
  int            got_run[$];
  int  busy_cycles, done_cnt, wait_cycles, drive_cycles, mon_bad, accepted;
  int  gap_after = -1, gap_cnt = 0, abort_arm = -1, run = 0;
  bit  gap_used, hs_pending, we_prev = 1'b1;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_data, popped;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Source driver and bus monitor share one block so in_valid and the sampled state agree.
  always @(negedge Clk) begin
    if (!Reset) begin
      we_prev = 1'b1; hs_pending = 1'b0; in_valid = 1'b0; gap_cnt = 0;
    end else begin
      if (hs_pending && src.size() > 0) begin popped = src.pop_front(); accepted++; end
      if (abort_arm > 0 && WE === 1'b0 && got_data.size() == abort_arm - 1) abort = 1'b1;
      if (gap_after >= 0 && !gap_used && in_ready === 1'b1 && accepted == gap_after) begin
        gap_cnt = GAP; gap_used = 1'b1;
      end
      in_valid = (src.size() > 0) && (gap_cnt == 0);
      if (gap_cnt > 0) gap_cnt--;
      in_data = (src.size() > 0) ? src[0] : '0;

      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) done_cnt++;
      if (drive_en === 1'b1) drive_cycles++;
      if (OE !== 1'b1) mon_bad++;
      if (in_ready === 1'b1) begin
        if (!in_valid) wait_cycles++;
        if (WE !== 1'b1 || drive_en !== 1'b0 || CE !== 1'b1 || busy !== 1'b1 || abort) mon_bad++;
      end
      if (WE === 1'b0) begin
        if (we_prev) begin cap_addr = ADDR; cap_data = data_to_tristate; run = 0; end
        run++;
        if (ADDR !== cap_addr || data_to_tristate !== cap_data || drive_en !== 1'b1 || CE !== 1'b0) mon_bad++;
        we_prev = 1'b0;
      end else if (!we_prev) begin
        if (ADDR !== cap_addr || data_to_tristate !== cap_data || drive_en !== 1'b1 || CE !== 1'b0) mon_bad++;
        got_addr.push_back(cap_addr); got_data.push_back(cap_data); got_run.push_back(run);
        we_prev = 1'b1;
      end
      hs_pending = in_valid && (in_ready === 1'b1) && !abort;
    end
  end

  // Expected writes: word i of the burst lands at (base + i) mod 2^AW carrying the i-th source word.
  task automatic burst(input logic [AW-1:0] base, input logic [AW-1:0] cnt,
                       input int gap_at, input int abort_w, input string name);
    logic [DW-1:0] exp_d[$];
    logic [DW-1:0] w;
    int n, wait_exp;
    @(negedge Clk); #1;
    src.delete();
    for (int i = 0; i < int'(cnt); i++) begin
      w = (fixed_q.size() > 0) ? fixed_q.pop_front() : DW'($urandom);
      src.push_back(w); exp_d.push_back(w);
    end
    got_addr.delete(); got_data.delete(); got_run.delete();
    busy_cycles = 0; done_cnt = 0; wait_cycles = 0; drive_cycles = 0; mon_bad = 0; accepted = 0;
    gap_after = gap_at; gap_used = 1'b0; abort_arm = abort_w;
    n = (abort_w > 0) ? abort_w : int'(cnt);
    wait_exp = (gap_at >= 0) ? GAP : 0;
    start = 1'b1; base_addr = base; word_count = cnt;
    @(negedge Clk); #1;
    start = 1'b0;
    chk({name, "_done_lag"}, {31'd0, done}, {31'd0, cnt == '0});
    for (int c = 0; c < 500 && done_cnt == 0; c++) @(negedge Clk);
    #1; abort = 1'b0; abort_arm = -1; gap_after = -1;
    repeat (3) @(negedge Clk);
    #1;
    chk({name, "_done_pulses"}, done_cnt, 1);
    chk({name, "_write_count"}, got_data.size(), n);
    for (int i = 0; i < got_data.size() && i < n; i++) begin
      chk($sformatf("%s_addr%0d", name, i), {12'd0, got_addr[i]}, (int'(base) + i) % (1 << AW));
      chk($sformatf("%s_data%0d", name, i), {16'd0, got_data[i]}, {16'd0, exp_d[i]});
      chk($sformatf("%s_we_len%0d", name, i), got_run[i], WEC);
    end
    if (cnt != '0) chk({name, "_words_written"}, {12'd0, words_written}, n);
    chk({name, "_busy_cycles"}, busy_cycles, (cnt == '0) ? 0 : n * (WEC + 3) + 1 + wait_exp);
    chk({name, "_drive_cycles"}, drive_cycles, n * (WEC + 2));
    chk({name, "_wait_cycles"}, wait_cycles, wait_exp);
    chk({name, "_bus_rules"}, mon_bad, 0);
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    #1;
    chk("rst_ctrl", {27'd0, CE, UB, LB, OE, WE}, 32'h1f);
    chk("rst_addr", {12'd0, ADDR}, 0);
    chk("rst_data", {16'd0, data_to_tristate}, 0);
    chk("rst_flags", {28'd0, drive_en, in_ready, busy, done}, 0);
    chk("rst_words", {12'd0, words_written}, 0);
    Reset = 1'b1;

    fixed_q.push_back(16'hAAAA); fixed_q.push_back(16'hBBBB); fixed_q.push_back(16'hCCCC);
    burst(20'h00100, 20'd3, -1, -1, "basic");
    burst(20'h00400, 20'd0, -1, -1, "zero");
    burst(20'hFFFFF, 20'd2, -1, -1, "wrap");
    burst(20'h12340, 20'd4, 2, -1, "gap");
    burst(20'h05000, 20'd5, -1, 2, "abort");
    burst(AW'($urandom), AW'($urandom_range(1, 6)), -1, -1, "rand");

    // Reset while WE is low must release the bus before any clock edge.
    @(negedge Clk); #1;
    src.delete(); src.push_back(16'h1234); src.push_back(16'h5678); src.push_back(16'h9abc);
    start = 1'b1; base_addr = 20'h00200; word_count = 20'd3;
    @(negedge Clk); #1;
    start = 1'b0;
    for (int c = 0; c < 50 && WE !== 1'b0; c++) @(negedge Clk);
    chk("mid_pulse_reached", {31'd0, WE}, 0);
    #2;
    Reset = 1'b0;
    #1;
    chk("async_rst_we", {31'd0, WE}, 1);
    chk("async_rst_drive", {31'd0, drive_en}, 0);
    chk("async_rst_busy", {31'd0, busy}, 0);
    @(negedge Clk); #1;
    Reset = 1'b1;
    burst(20'h00300, 20'd1, -1, -1, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
